// File: rtl/ula_muldiv_ctrl.sv
// ula_muldiv_ctrl: 32-bit unsigned MULTU/DIVU sequencer that borrows the EX-stage ALU as its adder/subtractor.
// Latency: start accepted at edge N, busy in cycles N+1..N+32, done pulse with HI/LO valid in cycle N+33.
// Backpressure: stalls the pipeline through busy; inicio is ignored while iterating (no queuing).
// Optional build macro ULA_DIV0_TRAP_EN: DIVU by zero completes in one cycle and raises erro_div0.
module ula_muldiv_ctrl (
    input  logic        clock,
    input  logic        reset,
    input  logic        inicio,
    input  logic        op,
    input  logic [31:0] entradaA,
    input  logic [31:0] entradaB,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_ctrl,
    input  logic [31:0] alu_saida,
    output logic        alu_sel,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        erro_div0
);

    localparam logic [3:0] ALU_NOP = 4'd0;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [4:0]  cnt;
    logic [4:0]  cnt_nxt;
    logic [31:0] opnd;
    logic [31:0] opnd_nxt;
    logic [31:0] hi_nxt;
    logic [31:0] lo_nxt;

    // Iteration helpers
    logic        start_ok;
    logic        last_iter;
    logic [31:0] sh;
    logic [31:0] sum;
    logic        carry;
    logic        sub_ok;

`ifdef ULA_DIV0_TRAP_EN
    logic        erro_q;
    logic        erro_nxt;
    logic        div0_start;

    // A DIVU with a zero divisor is short-circuited straight to DONE
    assign div0_start = op && (entradaB == 32'd0);
    assign erro_div0  = erro_q;
`else
    assign erro_div0  = 1'b0;
`endif

    // Starts are only honoured when no operation is in flight
    assign start_ok  = inicio && ((state == IDLE) || (state == DONE));
    assign last_iter = (cnt == 5'd31);

    // State register; reset aborts any operation in flight
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and Moore outputs; ALU drive comes from registered state only
    always_comb begin
        state_nxt = state;
        alu_a     = 32'd0;
        alu_b     = 32'd0;
        alu_ctrl  = ALU_NOP;
        alu_sel   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE, DONE: begin
                done      = (state == DONE);
                state_nxt = IDLE;
                if (start_ok) begin
                    if (op) begin
                        state_nxt = DIV;
`ifdef ULA_DIV0_TRAP_EN
                        if (div0_start) begin
                            state_nxt = DONE;
                        end
`endif
                    end else begin
                        state_nxt = MULT;
                    end
                end
            end
            MULT: begin
                alu_a    = hi;
                alu_b    = opnd;
                alu_ctrl = ALU_ADD;
                alu_sel  = 1'b1;
                busy     = 1'b1;
                if (last_iter) begin
                    state_nxt = DONE;
                end
            end
            DIV: begin
                alu_a    = sh;
                alu_b    = opnd;
                alu_ctrl = ALU_SUB;
                alu_sel  = 1'b1;
                busy     = 1'b1;
                if (last_iter) begin
                    state_nxt = DONE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Per-iteration arithmetic around the shared ALU result
    always_comb begin
        // Partial remainder shifted left by one, bringing in the next dividend bit
        sh = {hi[30:0], lo[31]};
        // Add step only when the current multiplier bit is set; a wrapped sum means carry out
        if (lo[0]) begin
            sum   = alu_saida;
            carry = (alu_saida < hi);
        end else begin
            sum   = hi;
            carry = 1'b0;
        end
        // hi[31] set means the true 33-bit remainder already exceeds any 32-bit divisor
        sub_ok = hi[31] || (sh >= opnd);
    end

    // Datapath next values: load on start, shift-add for MULTU, restoring shift-subtract for DIVU
    always_comb begin
        cnt_nxt  = cnt;
        opnd_nxt = opnd;
        hi_nxt   = hi;
        lo_nxt   = lo;
`ifdef ULA_DIV0_TRAP_EN
        erro_nxt = erro_q;
`endif
        case (state)
            IDLE, DONE: begin
                if (start_ok) begin
                    cnt_nxt = 5'd0;
                    hi_nxt  = 32'd0;
`ifdef ULA_DIV0_TRAP_EN
                    erro_nxt = 1'b0;
`endif
                    if (op) begin
                        lo_nxt   = entradaA;
                        opnd_nxt = entradaB;
`ifdef ULA_DIV0_TRAP_EN
                        // Same HI/LO the full algorithm would produce for a zero divisor
                        if (div0_start) begin
                            hi_nxt   = entradaA;
                            lo_nxt   = 32'hFFFF_FFFF;
                            erro_nxt = 1'b1;
                        end
`endif
                    end else begin
                        lo_nxt   = entradaB;
                        opnd_nxt = entradaA;
                    end
                end
            end
            MULT: begin
                {hi_nxt, lo_nxt} = {carry, sum, lo[31:1]};
                cnt_nxt          = cnt + 5'd1;
            end
            DIV: begin
                if (sub_ok) begin
                    hi_nxt = alu_saida;
                    lo_nxt = {lo[30:0], 1'b1};
                end else begin
                    hi_nxt = sh;
                    lo_nxt = {lo[30:0], 1'b0};
                end
                cnt_nxt = cnt + 5'd1;
            end
            default: begin
                cnt_nxt = cnt;
            end
        endcase
    end

    // Datapath registers; HI/LO hold their result until the next accepted start
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt  <= 5'd0;
            opnd <= 32'd0;
            hi   <= 32'd0;
            lo   <= 32'd0;
        end else begin
            cnt  <= cnt_nxt;
            opnd <= opnd_nxt;
            hi   <= hi_nxt;
            lo   <= lo_nxt;
        end
    end

`ifdef ULA_DIV0_TRAP_EN
    // Sticky divide-by-zero flag, cleared by the next accepted start
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            erro_q <= 1'b0;
        end else begin
            erro_q <= erro_nxt;
        end
    end
`endif

endmodule

// File: doc/ula_muldiv_ctrl.md
# ula_muldiv_ctrl

Multi-cycle sequencer for 32-bit unsigned multiply (MULTU) and divide (DIVU) that time-shares the execute-stage ALU as its adder/subtractor. It sits beside the EX stage: accepts an operation on a start pulse, drives the ALU operand and control lines for 32 iteration cycles, and stalls the pipeline through `busy`. On completion it holds the results in HI/LO and pulses `done`.

## Interface
- No parameters; width fixed at 32.
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- inicio  in  1  start request; sampled only in IDLE or DONE
- op  in  1  0 = MULTU, 1 = DIVU
- entradaA  in  32  multiplicand / dividend
- entradaB  in  32  multiplier / divisor
- alu_a  out  32  operand A to shared ALU
- alu_b  out  32  operand B to shared ALU
- alu_ctrl  out  4  ALU control: 2 = ADD, 6 = SUB, 0 when idle
- alu_saida  in  32  ALU result, combinational return
- alu_sel  out  1  1 = this block owns the ALU mux
- busy  out  1  pipeline stall request
- done  out  1  one-cycle completion pulse
- hi  out  32  MULTU high word / DIVU remainder
- lo  out  32  MULTU low word / DIVU quotient
- erro_div0  out  1  divide-by-zero flag (see Configuration)

## Operation
- States: IDLE, MULT, DIV, DONE. Internal: 5-bit iteration counter `cnt`, 32-bit operand register `opnd`.
- Start acceptance: `inicio = 1` in IDLE or DONE.
  - MULTU: `hi = 0`, `lo = entradaB`, `opnd = entradaA`, `cnt = 0`, next state MULT.
  - DIVU: `hi = 0`, `lo = entradaA`, `opnd = entradaB`, `cnt = 0`, next state DIV.
- MULT cycle (ALU driven with `alu_a = hi`, `alu_b = opnd`, `alu_ctrl = 2`):
  - If `lo[0] = 1`: `sum = alu_saida`, `carry = (alu_saida < hi)` (unsigned compare). Otherwise `sum = hi`, `carry = 0`.
  - Update `{hi, lo} <= {carry, sum, lo[31:1]}`.
- DIV cycle (ALU driven with `alu_a = {hi[30:0], lo[31]}`, `alu_b = opnd`, `alu_ctrl = 6`):
  - Let `sh` be `alu_a`.
  - If `hi[31] = 1` or `sh >= opnd` (unsigned): `hi <= alu_saida`, `lo <= {lo[30:0], 1}`.
  - Otherwise: `hi <= sh`, `lo <= {lo[30:0], 0}`.
- Termination: `cnt` increments each MULT/DIV cycle. The cycle with `cnt = 31` is the last iteration, then the state goes to DONE.
- DONE: `done = 1` for one cycle. Next state is IDLE, or MULT/DIV if `inicio = 1`.
- Results: `hi`/`lo` hold their values until the next accepted start.
- `alu_sel = 1` and `busy = 1` exactly in MULT and DIV. In all other states `alu_a = alu_b = 0` and `alu_ctrl = 0`.
- `inicio` asserted during MULT/DIV is ignored; there is no queuing.
- Divide by zero without the trap: the algorithm runs normally and yields `lo = 0xFFFFFFFF`, `hi = dividend`.

## Timing
- Reset (asynchronous, any state):
  - State goes to IDLE; `cnt`, `opnd`, `hi`, `lo` are cleared to 0.
  - `busy`, `done`, `alu_sel`, `erro_div0` are 0.
  - `alu_a`, `alu_b`, `alu_ctrl` are 0.
- Reset mid-operation aborts the operation; there is no result and no `done`.
- Latency: start accepted at edge N; `busy = 1` during cycles N+1 … N+32; `done = 1` and results valid in cycle N+33.
- Back-to-back operations: `inicio` held in DONE restarts with zero idle cycles; throughput is one operation per 33 cycles.
- `busy` and the ALU drive outputs are decoded from registered state only (Moore); there is no combinational path from `inicio`.
- `alu_saida` is expected to settle within the same cycle; the result is captured at the end of the iteration cycle.

## Configuration
- `ULA_DIV0_TRAP_EN` defined:
  - DIVU with `entradaB = 0` skips DIV and goes directly to DONE at edge N+1.
  - In that DONE cycle (N+1): `erro_div0 = 1`, `done = 1`, `hi = dividend`, `lo = 0xFFFFFFFF`, and `busy` stays 0.
  - `erro_div0` clears on the next accepted start or on reset.
- `ULA_DIV0_TRAP_EN` undefined:
  - `erro_div0` is tied to 0.
  - Division by zero takes the full 33 cycles with the natural result above.

## Test plan
- MULTU 7 × 6 -> `hi = 0`, `lo = 42`; `busy = 1` for exactly 32 cycles; `done` pulses at N+33; `alu_ctrl = 2` throughout the busy window.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> `hi = 0xFFFFFFFE`, `lo = 0x00000001` (exercises carry out).
- DIVU 100 / 7 -> `lo = 14`, `hi = 2`; DIVU 0x80000000 / 3 -> `lo = 0x2AAAAAAA`, `hi = 2`; `alu_ctrl = 6` while busy.
- DIVU 5 / 0:
  - With trap: `done` and `erro_div0` at N+1, `hi = 5`, `lo = 0xFFFFFFFF`, `busy` never asserted.
  - Without trap: same `hi`/`lo` at N+33 with `erro_div0 = 0`.
- `inicio` pulsed at busy cycle 10 with different operands -> ignored; first result unchanged; `inicio` held in DONE -> second operation starts with no gap.
- Reset asserted at busy cycle 15 -> all outputs 0 immediately (asynchronous), no `done`; a subsequent MULTU 3 × 4 gives `lo = 12`.
